slowram_ctrl: RTL and testbench

Responder-side controller for the 128 KB 1 MHz slow RAM (banks E0/E1), sitting between the iigs core's bus (bank/addr/dout/we) and the slowram array.
- Serves direct CPU reads and writes to E0/E1.
- Performs shadow copies of CPU writes to video regions of banks 00/01 into E0/E1.
- Aligns every slow-RAM access to a 1 MHz slot and stalls the CPU until the access completes.

---
 rtl/iigs_mem_pkg.sv | 32 +++
 rtl/shadow_decode.sv | 29 ++
 rtl/slowram_ctrl.sv | 101 ++++++++++
 tb/tb_slowram_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/iigs_mem_pkg.sv
// Shared bank, video-region and state definitions for the IIgs memory responders.
// Used by the slow-RAM controller and the shadow decoder.
package iigs_mem_pkg;

    localparam logic [7:0] BANK_00 = 8'h00;
    localparam logic [7:0] BANK_01 = 8'h01;
    localparam logic [7:0] BANK_E0 = 8'hE0;
    localparam logic [7:0] BANK_E1 = 8'hE1;

    localparam logic [15:0] TEXT_LO   = 16'h0400;
    localparam logic [15:0] TEXT_HI   = 16'h07FF;
    localparam logic [15:0] HIRES1_LO = 16'h2000;
    localparam logic [15:0] HIRES1_HI = 16'h3FFF;
    localparam logic [15:0] HIRES2_LO = 16'h4000;
    localparam logic [15:0] HIRES2_HI = 16'h5FFF;
    localparam logic [15:0] SHR_LO    = 16'h2000;
    localparam logic [15:0] SHR_HI    = 16'h9FFF;

    localparam int INH_TEXT   = 0;
    localparam int INH_HIRES1 = 1;
    localparam int INH_HIRES2 = 2;
    localparam int INH_SHR    = 3;

    typedef enum logic [1:0] {IDLE, WAIT_SLOT, ACCESS, DONE} slow_state_t;

    function automatic logic in_range(input logic [15:0] addr,
                                      input logic [15:0] lo,
                                      input logic [15:0] hi);
        return (addr >= lo) && (addr <= hi);
    endfunction

endpackage

// File: rtl/shadow_decode.sv
// Classifies a CPU bus cycle as a direct slow-RAM hit (E0/E1) or a shadowed
// video write from bank 00/01. Purely combinational.
module shadow_decode
    import iigs_mem_pkg::*;
(
    input  logic [7:0]  bank,
    input  logic [15:0] addr,
    input  logic        we,
    input  logic [3:0]  shadow_inh,
    output logic        direct_hit,
    output logic        shadow_hit
);

    logic low_bank;
    logic region_hit;

    always_comb begin
        direct_hit = (bank == BANK_E0) || (bank == BANK_E1);
        low_bank   = (bank == BANK_00) || (bank == BANK_01);
        // SHR only shadows from bank 01; the other regions shadow from both banks
        region_hit = (in_range(addr, TEXT_LO, TEXT_HI) && !shadow_inh[INH_TEXT])
                  || (in_range(addr, HIRES1_LO, HIRES1_HI) && !shadow_inh[INH_HIRES1])
                  || (in_range(addr, HIRES2_LO, HIRES2_HI) && !shadow_inh[INH_HIRES2])
                  || ((bank == BANK_01) && in_range(addr, SHR_LO, SHR_HI)
                      && !shadow_inh[INH_SHR]);
        shadow_hit = we && low_bank && region_hit;
    end

endmodule

// File: rtl/slowram_ctrl.sv
// Slow-RAM (banks E0/E1) responder: serves direct and shadowed accesses, each
// aligned to a 1 MHz slot, stalling the CPU until the access completes.
module slowram_ctrl
    import iigs_mem_pkg::*;
#(
    parameter int SLOT_DIV = 14
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic [7:0]  cpu_bank,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_we,
    input  logic [3:0]  shadow_inh,
    output logic        cpu_stall,
    output logic        cpu_ack,
    output logic [7:0]  cpu_rdata,
    output logic        slot_tick,
    output logic [16:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_wr,
    output logic        mem_ce,
    input  logic [7:0]  mem_rdata
);

    slow_state_t state;
    logic [7:0]  slot_cnt;
    logic [16:0] lat_addr;
    logic [7:0]  lat_wdata;
    logic        lat_we;
    logic        direct_hit;
    logic        shadow_hit;

    shadow_decode u_decode (
        .bank       (cpu_bank),
        .addr       (cpu_addr),
        .we         (cpu_we),
        .shadow_inh (shadow_inh),
        .direct_hit (direct_hit),
        .shadow_hit (shadow_hit)
    );

    assign slot_tick = (slot_cnt == 8'(SLOT_DIV - 1));
    assign cpu_stall = (state != IDLE);
    assign mem_ce    = (state == ACCESS);
    assign mem_wr    = (state == ACCESS) && lat_we;
    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;

    always_ff @(posedge clk_sys or negedge reset) begin
        if (!reset) begin
            slot_cnt <= '0;
        end else if (slot_tick) begin
            slot_cnt <= '0;
        end else begin
            slot_cnt <= slot_cnt + 8'd1;
        end
    end

    // Latches only load in IDLE, so requests during a stall cannot disturb them
    always_ff @(posedge clk_sys or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cpu_ack   <= 1'b0;
            cpu_rdata <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_we    <= 1'b0;
        end else begin
            cpu_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_req && (direct_hit || shadow_hit)) begin
                        lat_addr  <= {cpu_bank[0], cpu_addr};
                        lat_wdata <= cpu_wdata;
                        lat_we    <= cpu_we;
                        state     <= WAIT_SLOT;
                    end
                end
                WAIT_SLOT: begin
                    if (slot_tick) begin
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    state <= DONE;
                end
                DONE: begin
                    if (!lat_we) begin
                        cpu_rdata <= mem_rdata;
                    end
                    cpu_ack <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_slowram_ctrl.sv
// Directed plus randomized bench for slowram_ctrl with a transaction-level
// reference model of hit decoding, slot alignment latency and memory contents.
module tb_slowram_ctrl;

    localparam int SLOT_DIV = 14;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        cpu_req;
    logic [7:0]  cpu_bank;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_we;
    logic [3:0]  shadow_inh;
    logic        cpu_stall;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic        slot_tick;
    logic [16:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_wr;
    logic        mem_ce;
    logic [7:0]  mem_rdata = 8'h00;

    logic [7:0]  ram     [0:131071];
    logic [7:0]  ref_mem [0:131071];
    logic [7:0]  last_rdata;
    int unsigned edges;
    int          checks   = 0;
    int          failures = 0;

    slowram_ctrl #(.SLOT_DIV(SLOT_DIV)) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_bank   (cpu_bank),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_we     (cpu_we),
        .shadow_inh (shadow_inh),
        .cpu_stall  (cpu_stall),
        .cpu_ack    (cpu_ack),
        .cpu_rdata  (cpu_rdata),
        .slot_tick  (slot_tick),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wr     (mem_wr),
        .mem_ce     (mem_ce),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk_sys = ~clk_sys;

    // Slow RAM array: synchronous read with one cycle of latency
    always @(posedge clk_sys) begin
        if (mem_ce) begin
            if (mem_wr) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    // Clock edges since reset release; the slot position is this modulo SLOT_DIV
    always @(posedge clk_sys or negedge reset) begin
        if (!reset) edges <= 0;
        else        edges <= edges + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_hit(input logic [7:0] bank, input logic [15:0] addr,
                                   input logic we, input logic [3:0] inh);
        bit direct, shadow;
        direct = (bank == 8'hE0) || (bank == 8'hE1);
        shadow = we && (bank == 8'h00 || bank == 8'h01) &&
                 ((addr >= 16'h0400 && addr <= 16'h07FF && !inh[0]) ||
                  (addr >= 16'h2000 && addr <= 16'h3FFF && !inh[1]) ||
                  (addr >= 16'h4000 && addr <= 16'h5FFF && !inh[2]) ||
                  (bank == 8'h01 && addr >= 16'h2000 && addr <= 16'h9FFF && !inh[3]));
        return direct || shadow;
    endfunction

    task automatic wait_count(input int target);
        for (int i = 0; i <= SLOT_DIV && (edges % SLOT_DIV) != target; i++)
            @(negedge clk_sys);
        chk("align", edges % SLOT_DIV, target);
    endtask

    // Called at a negedge: presents one request and follows it to completion
    task automatic run_txn(input logic [7:0] bank, input logic [15:0] addr,
                           input logic [7:0] wdata, input logic we,
                           input logic [3:0] inh, input bit hold);
        bit          hit;
        int          c, d, span;
        logic [16:0] ea;
        hit  = ref_hit(bank, addr, we, inh);
        c    = edges % SLOT_DIV;
        d    = SLOT_DIV - 1 - c;
        if (d == 0) d = SLOT_DIV;
        ea   = {bank[0], addr};
        span = hit ? d + 3 : SLOT_DIV + 2;
        cpu_req = 1'b1; cpu_bank = bank; cpu_addr = addr;
        cpu_wdata = wdata; cpu_we = we; shadow_inh = inh;
        for (int k = 0; k <= span; k++) begin
            @(negedge clk_sys);
            if (hold && hit && k < d) begin
                cpu_req = 1'b1; cpu_bank = 8'hE0; cpu_addr = ~addr;
                cpu_wdata = ~wdata; cpu_we = ~we;
            end else begin
                cpu_req = 1'b0;
            end
            chk("slot_tick", slot_tick, (edges % SLOT_DIV) == SLOT_DIV - 1);
            chk("cpu_stall", cpu_stall, hit && k <= d + 1);
            chk("mem_ce", mem_ce, hit && k == d);
            chk("cpu_ack", cpu_ack, hit && k == d + 2);
            if (hit && k == d) begin
                chk("mem_addr", mem_addr, ea);
                chk("mem_wr", mem_wr, we);
                if (we) chk("mem_wdata", mem_wdata, wdata);
            end
            if (k == (hit ? d + 2 : span)) begin
                if (hit && !we) last_rdata = ref_mem[ea];
                chk("cpu_rdata", cpu_rdata, last_rdata);
            end
        end
        if (hit && we) ref_mem[ea] = wdata;
    endtask

    initial begin
        logic [7:0]  rb;
        logic [15:0] ra;
        logic [7:0]  banks [5];
        reset = 1'b0; cpu_req = 1'b0; cpu_bank = '0; cpu_addr = '0;
        cpu_wdata = '0; cpu_we = 1'b0; shadow_inh = '0; last_rdata = 8'h00;
        for (int i = 0; i < 131072; i++) begin
            rb = 8'($urandom);
            ram[i] = rb; ref_mem[i] = rb;
        end
        ram[17'h01234] = 8'h5A; ref_mem[17'h01234] = 8'h5A;
        #12;
        chk("rst_stall", cpu_stall, 0);
        chk("rst_ack", cpu_ack, 0);
        chk("rst_rdata", cpu_rdata, 0);
        chk("rst_ce", mem_ce, 0);
        chk("rst_wr", mem_wr, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        @(negedge clk_sys);
        reset = 1'b1;

        wait_count(3);
        run_txn(8'hE1, 16'h1234, 8'h00, 1'b0, 4'b0000, 1'b0);
        run_txn(8'h00, 16'h0400, 8'hC1, 1'b1, 4'b0000, 1'b0);
        run_txn(8'h00, 16'h0400, 8'hC2, 1'b1, 4'b0001, 1'b0);
        run_txn(8'h01, 16'h8000, 8'h77, 1'b1, 4'b0000, 1'b0);
        run_txn(8'h00, 16'h8000, 8'h66, 1'b1, 4'b0000, 1'b0);
        run_txn(8'h01, 16'h8000, 8'h55, 1'b1, 4'b1000, 1'b0);
        wait_count(SLOT_DIV - 1);
        run_txn(8'hE0, 16'h0400, 8'h00, 1'b0, 4'b0000, 1'b0);
        run_txn(8'hFE, 16'h1000, 8'h00, 1'b0, 4'b0000, 1'b0);
        run_txn(8'h00, 16'h0400, 8'h00, 1'b0, 4'b0000, 1'b0);
        wait_count(5);
        run_txn(8'hE1, 16'h2222, 8'h3C, 1'b1, 4'b0000, 1'b1);
        run_txn(8'hE1, 16'h2222, 8'h00, 1'b0, 4'b0000, 1'b1);

        // Abort an access while it waits for its slot
        wait_count(0);
        cpu_req = 1'b1; cpu_bank = 8'hE0; cpu_addr = 16'h0010; cpu_we = 1'b0;
        @(negedge clk_sys); cpu_req = 1'b0;
        @(negedge clk_sys); @(negedge clk_sys);
        chk("pre_rst_stall", cpu_stall, 1);
        #2 reset = 1'b0;
        #1;
        chk("abort_stall", cpu_stall, 0);
        chk("abort_rdata", cpu_rdata, 0);
        last_rdata = 8'h00;
        @(negedge clk_sys);
        reset = 1'b1;
        for (int k = 0; k < 2 * SLOT_DIV; k++) begin
            @(negedge clk_sys);
            chk("post_rst_ce", mem_ce, 0);
            chk("post_rst_ack", cpu_ack, 0);
            chk("post_rst_stall", cpu_stall, 0);
        end

        banks = '{8'h00, 8'h01, 8'hE0, 8'hE1, 8'h42};
        for (int n = 0; n < 40; n++) begin
            int idle;
            idle = int'($urandom_range(0, SLOT_DIV));
            for (int i = 0; i < idle; i++) @(negedge clk_sys);
            rb = banks[$urandom_range(0, 4)];
            case ($urandom_range(0, 3))
                0:       ra = 16'($urandom_range(16'h0400, 16'h07FF));
                1:       ra = 16'($urandom_range(16'h2000, 16'h5FFF));
                2:       ra = 16'($urandom_range(16'h6000, 16'h9FFF));
                default: ra = 16'($urandom);
            endcase
            run_txn(rb, ra, 8'($urandom), 1'($urandom), 4'($urandom), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
